// File: rtl/sub12_pkg.sv
// Shared types and default sizing for the serial subtractor.
package sub12_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int W_DEF       = 12;
  localparam int SLICE_W_DEF = 4;
endpackage

// File: rtl/sub4_slice.sv
// One SLICE_W-bit ripple-borrow subtract slice: {bout,d} = a - b - bin.
module sub4_slice #(
  parameter int SLICE_W = sub12_pkg::SLICE_W_DEF
) (
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               bin,
  output logic [SLICE_W-1:0] d,
  output logic               bout
);
  always_comb begin
    logic br;
    br = bin;
    d  = '0;
    for (int i = 0; i < SLICE_W; i++) begin
      d[i] = a[i] ^ b[i] ^ br;
      br   = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br);
    end
    bout = br;
  end
endmodule

// File: rtl/sub12_serial.sv
// Serial A-B-Bin subtractor, one slice per cycle; SUB12_SERIAL_SAT_EN clamps D to 0 on borrow.
// state | meaning: IDLE accept start / CALC one slice per cycle / DONE one-cycle result pulse
module sub12_serial
  import sub12_pkg::*;
#(
  parameter int W       = W_DEF,
  parameter int SLICE_W = SLICE_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         Bin,
  output logic         ready,
  output logic         busy,
  output logic [W-1:0] D,
  output logic         Bout,
  output logic         done
);
  localparam int N     = W / SLICE_W;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  state_t             state, state_nxt;
  logic [W-1:0]       a_q, b_q, acc, result;
  logic               borrow;
  logic [IDX_W-1:0]   idx;
  logic [SLICE_W-1:0] diff;
  logic               slice_bout;
  logic               last;

  assign last = (idx == IDX_W'(N - 1));

  sub4_slice #(.SLICE_W(SLICE_W)) u_slice (
    .a    (a_q[int'(idx)*SLICE_W +: SLICE_W]),
    .b    (b_q[int'(idx)*SLICE_W +: SLICE_W]),
    .bin  (borrow),
    .d    (diff),
    .bout (slice_bout)
  );

  // Partial result with the current slice merged in; only reaches D on the final slice.
  always_comb begin
    result = acc;
    result[int'(idx)*SLICE_W +: SLICE_W] = diff;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign ready = (state == IDLE);
  assign busy  = (state == CALC);
  assign done  = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      acc    <= '0;
      borrow <= 1'b0;
      idx    <= '0;
      D      <= '0;
      Bout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q    <= A;
            b_q    <= B;
            borrow <= Bin;
            acc    <= '0;
            idx    <= '0;
          end
        end
        CALC: begin
          acc    <= result;
          borrow <= slice_bout;
          idx    <= idx + IDX_W'(1);
          if (last) begin
            idx  <= '0;
            Bout <= slice_bout;
`ifdef SUB12_SERIAL_SAT_EN
            D    <= slice_bout ? '0 : result;
`else
            D    <= result;
`endif
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sub12_serial.sv
// Scoreboard bench for sub12_serial: randomized and directed operands against an arithmetic model.
module tb_sub12_serial;
  localparam int W = 12;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] A = '0, B = '0;
  logic         Bin = 1'b0;
  logic         ready, busy, done, Bout;
  logic [W-1:0] D;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  logic [W:0] exp_q[$];
  int done_times[$];

  sub12_serial dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .Bin(Bin),
    .ready(ready), .busy(busy), .D(D), .Bout(Bout), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    int diff;
    logic [W:0] r;
    diff = int'(a) - int'(b) - int'(bin);
    r = (W+1)'(diff + (1 << (W+1)));
`ifdef SUB12_SERIAL_SAT_EN
    if (diff < 0) r = {1'b1, {W{1'b0}}};
`endif
    return r;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (!rst && done) begin
      done_cnt++;
      done_times.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual D=%0h Bout=%b required none", D, Bout);
      end else begin
        chk("result", 32'({Bout, D}), 32'(exp_q.pop_front()));
      end
    end
  end

  // Waits for ready, presents one request for one edge, then scrambles the inputs.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    int t = 0;
    do begin @(negedge clk); t++; end while (!ready && t < 50);
    if (!ready) begin
      checks++; errors++;
      $display("FAIL ready_timeout actual=0 required=1");
      return;
    end
    start = 1'b1; A = a; B = b; Bin = bin;
    exp_q.push_back(model(a, b, bin));
    @(negedge clk);
    start = 1'b0;
    A = W'($urandom); B = W'($urandom); Bin = 1'($urandom);
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 200) begin @(negedge clk); t++; end
    repeat (3) @(negedge clk);
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    int d0;
    #12;
    chk("rst_ready", ready, 1); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    chk("rst_D", D, 0); chk("rst_Bout", Bout, 0);
    @(negedge clk); rst = 1'b0;

    // Latency profile for 100-37.
    issue(12'd100, 12'd37, 1'b0);
    chk("e0_busy", busy, 1);
    @(negedge clk); chk("e1_done", done, 0);
    @(negedge clk); chk("e2_done", done, 0); chk("e2_busy", busy, 1);
    @(negedge clk); chk("e3_done", done, 1); chk("e3_D", D, 63); chk("e3_ready", ready, 0);
    @(negedge clk); chk("e4_ready", ready, 1); chk("e4_done", done, 0); chk("e4_D_held", D, 63);

    issue(12'h000, 12'h001, 1'b0);
    issue(12'h100, 12'h001, 1'b0);
    issue(12'h005, 12'h005, 1'b1);
    issue(12'hFFF, 12'h000, 1'b1);
    drain();

    // Start during CALC must be dropped.
    d0 = done_cnt;
    issue(12'h123, 12'h045, 1'b0);
    start = 1'b1; A = 12'h777; B = 12'h111; Bin = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (8) @(negedge clk);
    chk("calc_start_ignored_dones", done_cnt - d0, 1);
    chk("calc_start_q_empty", exp_q.size(), 0);

    // Reset in the middle of CALC.
    d0 = done_cnt;
    issue(12'h800, 12'h001, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_ready", ready, 1); chk("abort_busy", busy, 0); chk("abort_done", done, 0);
    chk("abort_D", D, 0); chk("abort_Bout", Bout, 0);
    void'(exp_q.pop_back());
    @(negedge clk); rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_no_done", done_cnt - d0, 0);
    issue(12'd9, 12'd4, 1'b0);
    drain();

    // Start held high: back-to-back acceptance every 5 cycles.
    d0 = done_cnt;
    done_times.delete();
    start = 1'b1; A = 12'hFFF; B = 12'hFFF; Bin = 1'b0;
    repeat (4) exp_q.push_back(model(12'hFFF, 12'hFFF, 1'b0));
    repeat (20) @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    chk("hold_dones", done_cnt - d0, 4);
    if (done_times.size() == 4)
      for (int i = 1; i < 4; i++) chk("hold_period", done_times[i] - done_times[i-1], 5);
    drain();

    // Randomized operands with random gaps.
    for (int n = 0; n < 40; n++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom); rb = W'($urandom);
      if (n % 5 == 0) rb = ra;
      issue(ra, rb, 1'($urandom));
      repeat ($urandom_range(0, 6)) @(negedge clk);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/sub12_serial.md
SUB12_SERIAL -- requirements
Module: sub12_serial

Interface
REQ-001 Parameter W, default 12, operand/result width in bits.
REQ-002 Parameter SLICE_W, default 4, bits processed per cycle; W SHALL be an integer multiple of SLICE_W.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request to begin a subtraction; sampled only while ready=1.
REQ-006 A  input  W  minuend; captured on an accepted start.
REQ-007 B  input  W  subtrahend; captured on an accepted start.
REQ-008 Bin  input  1  borrow in; captured on an accepted start.
REQ-009 ready  output  1  high only in IDLE; the block accepts start.
REQ-010 busy  output  1  high in CALC.
REQ-011 D  output  W  difference A-B-Bin, held until the next completion.
REQ-012 Bout  output  1  borrow out of the MSB, held with D.
REQ-013 done  output  1  one-cycle pulse; D/Bout are valid and newly updated.

Function
REQ-014 FSM states SHALL be IDLE, CALC and DONE.
REQ-015 IDLE->CALC on start=1 at a rising edge; A, B and Bin SHALL be registered, the slice index cleared, and the borrow register loaded with Bin.
REQ-016 CALC SHALL process one SLICE_W-bit slice per cycle, LSB slice first, and register the slice difference and the slice borrow.
REQ-017 CALC->DONE after the W/SLICE_W-th slice edge (edge 3 for defaults, counting the start-sampling edge as edge 0).
REQ-018 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-019 D and Bout SHALL update only on the CALC->DONE edge; intermediate slices SHALL be held in an internal register, never on D.
REQ-020 Arithmetic: {Bout,D} = A - B - Bin modulo 2^(W+1); Bout=1 iff A < B+Bin as unsigned values.
REQ-021 start while ready=0 SHALL be ignored and SHALL NOT corrupt the operation in progress.
REQ-022 start held high SHALL be accepted again on the first IDLE cycle after DONE; throughput is one result per W/SLICE_W+2 cycles.
REQ-023 Input changes on A/B/Bin after acceptance SHALL NOT affect the result.

Reset
REQ-024 rst=1 SHALL force IDLE immediately: ready=1, busy=0, done=0, D=0, Bout=0, slice index=0, borrow register=0.
REQ-025 rst during CALC SHALL abort the operation with no done pulse; the first start after rst release SHALL be accepted normally.

Configuration
REQ-026 Macro SUB12_SERIAL_SAT_EN defined: when the final borrow is 1, D SHALL be forced to 0 (unsigned saturation), and Bout SHALL still report 1.
REQ-027 SUB12_SERIAL_SAT_EN undefined: D SHALL be the wrapped modular difference per REQ-020.

Structure
REQ-028 Shared package sub12_pkg SHALL hold the FSM state enum typedef and the default W and SLICE_W constants.
REQ-029 Sub-module sub4_slice SHALL implement one combinational SLICE_W-bit ripple-borrow subtract (a, b, bin -> d, bout), instantiated once and time-multiplexed across slices.

Verification
REQ-030 A=100, B=37, Bin=0, start at edge 0 -> done high after edge 3, D=63, Bout=0; ready high again after edge 4.
REQ-031 A=0x000, B=0x001, Bin=0 -> D=0xFFF, Bout=1; with SUB12_SERIAL_SAT_EN -> D=0x000, Bout=1.
REQ-032 Cross-slice borrow: A=0x100, B=0x001 -> D=0x0FF, Bout=0; A=0x005, B=0x005, Bin=1 -> D=0xFFF, Bout=1.
REQ-033 start pulsed during CALC with different operands -> first result unchanged, second request dropped, exactly one done pulse.
REQ-034 rst asserted after edge 1 of CALC -> outputs at reset values immediately, no done pulse; next start with A=9, B=4 -> D=5, Bout=0.
REQ-035 start held high for 20 cycles with A=0xFFF, B=0xFFF -> a done pulse every 5 cycles, each with D=0x000, Bout=0.
